// File: rtl/com_image_loader_pkg.sv
// Shared definitions for the UART image loader: sync bytes, FSM states and
// the physical address type used for memory byte writes.
package com_image_loader_pkg;

  localparam logic [7:0] SYNC0_BYTE = 8'h11;
  localparam logic [7:0] SYNC1_BYTE = 8'h55;
  localparam int         ADDR_W     = 20;

  typedef logic [ADDR_W-1:0] phys_addr_t;

  typedef enum logic [2:0] {
    SYNC0  = 3'd0,
    SYNC1  = 3'd1,
    LEN_HI = 3'd2,
    LEN_LO = 3'd3,
    DATA   = 3'd4,
    FIN    = 3'd5
  } state_t;

endpackage

// File: rtl/com_image_loader.sv
// Parses 0x11 0x55 LEN16 framed images from a byte stream and turns each data
// byte into a single-outstanding memory byte write at BASE_ADDR + index.
module com_image_loader
  import com_image_loader_pkg::*;
#(
  parameter phys_addr_t BASE_ADDR      = 20'h10100,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axis_rx_tvalid,
  output logic        s_axis_rx_tready,
  input  logic [7:0]  s_axis_rx_tdata,
  output logic        m_axis_wr_tvalid,
  input  logic        m_axis_wr_tready,
  output logic [19:0] m_axis_wr_taddr,
  output logic [7:0]  m_axis_wr_tdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] img_len,
  output logic [7:0]  img_sum
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            state_r, state_nx;
  logic [7:0]        len_hi_r;
  logic [15:0]       img_len_r;
  logic [7:0]        img_sum_r;
  logic [15:0]       idx_r;
  logic [IDLE_W-1:0] idle_r;
  logic              wr_valid_r;
  phys_addr_t        wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              busy_r, done_r, err_r;

  logic        rx_fire_s, data_fire_s, last_byte_s;
  logic        idle_run_s, timeout_s, finish_s;
  logic [15:0] len_s;

  assign s_axis_rx_tready = (state_r != DATA) || !wr_valid_r || m_axis_wr_tready;
  assign rx_fire_s        = s_axis_rx_tvalid && s_axis_rx_tready;
  assign data_fire_s      = rx_fire_s && (state_r == DATA);
  assign len_s            = {len_hi_r, s_axis_rx_tdata};
  assign last_byte_s      = (idx_r == (img_len_r - 16'd1));
  // A write stalled by the memory side is not an idle input, so it holds the counter at zero.
  assign idle_run_s = (state_r == LEN_HI) || (state_r == LEN_LO) ||
                      ((state_r == DATA) && (!wr_valid_r || m_axis_wr_tready));
  assign timeout_s  = idle_run_s && !rx_fire_s && (idle_r == IDLE_LAST);

  // Next-state decode for the frame parser.
  always_comb begin
    state_nx = state_r;
    finish_s = 1'b0;
    case (state_r)
      SYNC0: begin
        if (rx_fire_s && (s_axis_rx_tdata == SYNC0_BYTE)) state_nx = SYNC1;
        else                                              state_nx = SYNC0;
      end
      SYNC1: begin
        if (!rx_fire_s)                              state_nx = SYNC1;
        else if (s_axis_rx_tdata == SYNC1_BYTE)      state_nx = LEN_HI;
        else if (s_axis_rx_tdata == SYNC0_BYTE)      state_nx = SYNC1;
        else                                         state_nx = SYNC0;
      end
      LEN_HI: begin
        if (timeout_s)      state_nx = SYNC0;
        else if (rx_fire_s) state_nx = LEN_LO;
        else                state_nx = LEN_HI;
      end
      LEN_LO: begin
        if (timeout_s)      state_nx = SYNC0;
        else if (rx_fire_s) state_nx = (len_s == 16'd0) ? FIN : DATA;
        else                state_nx = LEN_LO;
      end
      DATA: begin
        if (timeout_s)                       state_nx = SYNC0;
        else if (data_fire_s && last_byte_s) state_nx = FIN;
        else                                 state_nx = DATA;
      end
      FIN: begin
        if (!wr_valid_r || m_axis_wr_tready) begin
          finish_s = 1'b1;
          state_nx = SYNC0;
        end else begin
          state_nx = FIN;
        end
      end
      default: state_nx = SYNC0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= SYNC0;
    else       state_r <= state_nx;
  end

  // Header capture, write register, checksum, idle counter and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_r   <= 8'd0;
      img_len_r  <= 16'd0;
      img_sum_r  <= 8'd0;
      idx_r      <= 16'd0;
      idle_r     <= '0;
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= finish_s;
      err_r  <= timeout_s;

      if ((state_r == SYNC1) && rx_fire_s && (s_axis_rx_tdata == SYNC1_BYTE)) busy_r <= 1'b1;
      else if (finish_s || timeout_s)                                         busy_r <= 1'b0;

      if (!idle_run_s || rx_fire_s || timeout_s) idle_r <= '0;
      else                                       idle_r <= idle_r + 1'b1;

      if ((state_r == LEN_HI) && rx_fire_s) len_hi_r <= s_axis_rx_tdata;

      if ((state_r == LEN_LO) && rx_fire_s) begin
        img_len_r <= len_s;
        img_sum_r <= 8'd0;
        idx_r     <= 16'd0;
      end

      // A pending write may retire in the same cycle a new byte replaces it.
      if (data_fire_s) begin
        wr_valid_r <= 1'b1;
        wr_addr_r  <= BASE_ADDR + phys_addr_t'(idx_r);
        wr_data_r  <= s_axis_rx_tdata;
        img_sum_r  <= img_sum_r + s_axis_rx_tdata;
        idx_r      <= idx_r + 16'd1;
      end else if (m_axis_wr_tready) begin
        wr_valid_r <= 1'b0;
      end
    end
  end

  assign m_axis_wr_tvalid = wr_valid_r;
  assign m_axis_wr_taddr  = wr_addr_r;
  assign m_axis_wr_tdata  = wr_data_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;
  assign img_len          = img_len_r;
  assign img_sum          = img_sum_r;

endmodule
